// File: rtl/alu_arbiter_if.sv
// Request, shared-ALU and response signals of alu_arbiter.
// The slave modport is the arbiter's view; master is the requester/ALU/consumer side.
interface alu_arbiter_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
);
   logic [1:0]       i_req_valid;
   logic [1:0]       o_req_ready;
   logic [WIDTH-1:0] i_req0_arg0;
   logic [WIDTH-1:0] i_req0_arg1;
   logic [WIDTH-1:0] i_req1_arg0;
   logic [WIDTH-1:0] i_req1_arg1;
   logic [1:0]       i_req0_oper;
   logic [1:0]       i_req1_oper;
   logic [WIDTH-1:0] o_alu_arg0;
   logic [WIDTH-1:0] o_alu_arg1;
   logic [1:0]       o_alu_oper;
   logic [WIDTH-1:0] i_alu_result;
   logic [3:0]       i_alu_flag;
   logic             o_rsp_valid;
   logic             o_rsp_id;
   logic [WIDTH-1:0] o_rsp_result;
   logic [3:0]       o_rsp_flag;
   logic             i_rsp_ready;
   logic             o_busy;
   logic [CNT_W-1:0] o_op_cnt;

   modport slave (
      input  i_req_valid, i_req0_arg0, i_req0_arg1, i_req1_arg0, i_req1_arg1,
      input  i_req0_oper, i_req1_oper, i_alu_result, i_alu_flag, i_rsp_ready,
      output o_req_ready, o_alu_arg0, o_alu_arg1, o_alu_oper,
      output o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_flag, o_busy, o_op_cnt
   );

   modport master (
      output i_req_valid, i_req0_arg0, i_req0_arg1, i_req1_arg0, i_req1_arg1,
      output i_req0_oper, i_req1_oper, i_alu_result, i_alu_flag, i_rsp_ready,
      input  o_req_ready, o_alu_arg0, o_alu_arg1, o_alu_oper,
      input  o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_flag, o_busy, o_op_cnt
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared ALU with a one-cycle registered result.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins) instead of round-robin.
module alu_arbiter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input logic          i_clk,
   input logic          i_rstn,
   alu_arbiter_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StExec, StCapt, StResp} state_e;

   state_e           state_q, state_d;
   logic             grant_id;
   logic             hs;
   logic             rsp_acc;
   logic [WIDTH-1:0] arg0_q, arg1_q, rsp_result_q;
   logic [1:0]       oper_q;
   logic             id_q;
   logic [3:0]       rsp_flag_q;
   logic [CNT_W-1:0] cnt_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
   assign grant_id = ~bus.i_req_valid[0];
`else
   logic ptr_q, ptr_d;

   // The pointer only matters when both requesters are valid.
   assign grant_id = (bus.i_req_valid == 2'b11) ? ptr_q : bus.i_req_valid[1];
   assign ptr_d    = hs ? ~grant_id : ptr_q;

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      hs      = 1'b0;
      rsp_acc = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.i_req_valid != 2'b00) begin
               hs      = 1'b1;
               state_d = StExec;
            end
         end
         StExec: state_d = StCapt;
         StCapt: state_d = StResp;
         StResp: begin
            if (bus.i_rsp_ready) begin
               rsp_acc = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         arg0_q       <= '0;
         arg1_q       <= '0;
         oper_q       <= 2'b00;
         id_q         <= 1'b0;
         rsp_result_q <= '0;
         rsp_flag_q   <= 4'h0;
         cnt_q        <= '0;
      end else begin
         if (hs) begin
            id_q   <= grant_id;
            arg0_q <= grant_id ? bus.i_req1_arg0 : bus.i_req0_arg0;
            arg1_q <= grant_id ? bus.i_req1_arg1 : bus.i_req0_arg1;
            oper_q <= grant_id ? bus.i_req1_oper : bus.i_req0_oper;
         end
         if (state_q == StCapt) begin
            rsp_result_q <= bus.i_alu_result;
            rsp_flag_q   <= bus.i_alu_flag;
         end
         if (rsp_acc) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Ready and busy are forced low while reset is held, whatever the state register holds.
   assign bus.o_req_ready  = (hs && i_rstn) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
   assign bus.o_busy       = i_rstn && (state_q != StIdle);
   assign bus.o_rsp_valid  = (state_q == StResp);
   assign bus.o_rsp_id     = id_q;
   assign bus.o_rsp_result = rsp_result_q;
   assign bus.o_rsp_flag   = rsp_flag_q;
   assign bus.o_alu_arg0   = arg0_q;
   assign bus.o_alu_arg1   = arg1_q;
   assign bus.o_alu_oper   = oper_q;
   assign bus.o_op_cnt     = cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: models the shared ALU and scores responses against a queue
// of expected results pushed at each request handshake.
module tb_alu_arbiter;
   localparam int unsigned W  = 4;
   localparam int unsigned CW = 8;

   typedef struct packed {
      logic       id;
      logic [3:0] flg;
      logic [3:0] res;
   } exp_t;

   logic clk = 1'b0;
   logic rstn;
   int   checks = 0;
   int   errors = 0;
   logic b_ptr = 1'b0;
   exp_t exp_q[$];

   alu_arbiter_if #(.WIDTH(W), .CNT_W(CW)) bus ();

   alu_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
      .i_clk  (clk),
      .i_rstn (rstn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Shared ALU: 00 xor, 01 sub, 10 and, 11 add; flags {carry, zero, neg, parity}.
   function automatic logic [7:0] alu_calc(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] op);
      logic [4:0] r;
      case (op)
         2'b00:   r = {1'b0, a ^ b};
         2'b01:   r = {1'b0, a} - {1'b0, b};
         2'b10:   r = {1'b0, a & b};
         default: r = {1'b0, a} + {1'b0, b};
      endcase
      return {r[4], (r[3:0] == 4'd0), r[3], ^r[3:0], r[3:0]};
   endfunction

   always @(posedge clk) begin
      {bus.i_alu_flag, bus.i_alu_result} <= alu_calc(bus.o_alu_arg0, bus.o_alu_arg1,
                                                     bus.o_alu_oper);
   end

   task automatic set_req(input logic id, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] op);
      if (id) begin
         bus.i_req1_arg0 = a;
         bus.i_req1_arg1 = b;
         bus.i_req1_oper = op;
      end else begin
         bus.i_req0_arg0 = a;
         bus.i_req0_arg1 = b;
         bus.i_req0_oper = op;
      end
      bus.i_req_valid[id] = 1'b1;
   endtask

   task automatic push_expected();
      logic       g;
      logic [7:0] r;
      if (bus.i_req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         g = 1'b0;
`else
         g = b_ptr;
`endif
      end else begin
         g = bus.i_req_valid[1];
      end
      b_ptr = ~g;
      r = g ? alu_calc(bus.i_req1_arg0, bus.i_req1_arg1, bus.i_req1_oper)
            : alu_calc(bus.i_req0_arg0, bus.i_req0_arg1, bus.i_req0_oper);
      exp_q.push_back(exp_t'({g, r}));
   endtask

   // Called just after a falling edge; returns just after the falling edge following the
   // handshake edge. n counts idle sample points before the handshake.
   task automatic wait_hs(output logic [1:0] rdy, output int n, output logic to);
      rdy = 2'b00;
      n   = 0;
      to  = 1'b1;
      for (int i = 0; i < 32 && to; i++) begin
         #1;
         if ((bus.i_req_valid & bus.o_req_ready) != 2'b00) begin
            rdy = bus.o_req_ready;
            n   = i;
            to  = 1'b0;
            push_expected();
         end
         @(negedge clk);
      end
   endtask

   task automatic wait_rsp(output exp_t got, output int n, output logic to);
      got = '0;
      n   = 0;
      to  = 1'b1;
      for (int i = 0; i < 32 && to; i++) begin
         #1;
         if (bus.o_rsp_valid === 1'b1) begin
            got = {bus.o_rsp_id, bus.o_rsp_flag, bus.o_rsp_result};
            n   = i;
            to  = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
   endtask

   task automatic pop_exp(output exp_t e);
      e = '1;
      if (exp_q.size() != 0) e = exp_q.pop_front();
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      bus.i_req_valid = 2'b11;
      bus.i_rsp_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (bus.o_req_ready !== 2'b00) begin
         errors++; $display("FAIL reset_ready got %b want 00", bus.o_req_ready);
      end
      checks++;
      if (bus.o_busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy got %b want 0", bus.o_busy);
      end
      checks++;
      if (bus.o_rsp_valid !== 1'b0) begin
         errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.o_rsp_valid);
      end
      checks++;
      if (bus.o_op_cnt !== 8'd0) begin
         errors++; $display("FAIL reset_op_cnt got %0d want 0", bus.o_op_cnt);
      end
      checks++;
      if ({bus.o_alu_arg0, bus.o_alu_arg1, bus.o_alu_oper} !== 10'd0) begin
         errors++; $display("FAIL reset_alu got %h/%h/%b want 0/0/00", bus.o_alu_arg0,
                            bus.o_alu_arg1, bus.o_alu_oper);
      end
      checks++;
      if ({bus.o_rsp_id, bus.o_rsp_flag, bus.o_rsp_result} !== 9'd0) begin
         errors++; $display("FAIL reset_rsp got %b/%h/%h want 0", bus.o_rsp_id,
                            bus.o_rsp_flag, bus.o_rsp_result);
      end
      @(negedge clk);
      rstn = 1'b1;
      bus.i_req_valid = 2'b00;
      b_ptr = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_req0_single();
      logic [1:0] rdy;
      int         n;
      logic       to;
      exp_t       got, e;
      set_req(1'b0, 4'd3, 4'd7, 2'b00);
      bus.i_rsp_ready = 1'b1;
      wait_hs(rdy, n, to);
      bus.i_req_valid = 2'b00;
      checks++;
      if (to || rdy !== 2'b01) begin
         errors++; $display("FAIL req0_grant got %b timeout %b want 01", rdy, to);
      end
      wait_rsp(got, n, to);
      // Valid must be visible in the cycle ending at the third edge after the handshake.
      checks++;
      if (to || n != 2) begin
         errors++; $display("FAIL req0_latency got %0d timeout %b want 2", n, to);
      end
      pop_exp(e);
      checks++;
      if (got !== e) begin
         errors++; $display("FAIL req0_rsp got %h want %h", got, e);
      end
      checks++;
      if (got.res !== 4'd4 || got.id !== 1'b0) begin
         errors++; $display("FAIL req0_result got %h id %b want 4 id 0", got.res, got.id);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.o_rsp_valid !== 1'b0 || bus.o_op_cnt !== 8'd1) begin
         errors++; $display("FAIL req0_done got valid %b cnt %0d want 0 1", bus.o_rsp_valid,
                            bus.o_op_cnt);
      end
   endtask

   task automatic test_req1_busy();
      logic [1:0] rdy;
      int         n;
      logic       to;
      exp_t       got, e;
      set_req(1'b1, 4'hF, 4'h1, 2'b01);
      #1;
      checks++;
      if (bus.o_busy !== 1'b0) begin
         errors++; $display("FAIL busy_idle got %b want 0", bus.o_busy);
      end
      wait_hs(rdy, n, to);
      bus.i_req_valid = 2'b00;
      checks++;
      if (to || rdy !== 2'b10) begin
         errors++; $display("FAIL req1_grant got %b timeout %b want 10", rdy, to);
      end
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (bus.o_busy !== 1'b1) begin
            errors++; $display("FAIL busy_active cycle %0d got %b want 1", i, bus.o_busy);
         end
         if (i < 2) @(negedge clk);
      end
      checks++;
      if (bus.o_rsp_valid !== 1'b1) begin
         errors++; $display("FAIL req1_valid got %b want 1", bus.o_rsp_valid);
      end
      got = {bus.o_rsp_id, bus.o_rsp_flag, bus.o_rsp_result};
      pop_exp(e);
      checks++;
      if (got !== e || got.res !== 4'hE || got.id !== 1'b1) begin
         errors++; $display("FAIL req1_rsp got %h want %h (result E id 1)", got, e);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.o_busy !== 1'b0 || bus.o_op_cnt !== 8'd2) begin
         errors++; $display("FAIL req1_done got busy %b cnt %0d want 0 2", bus.o_busy,
                            bus.o_op_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] rdy;
      int         n;
      logic       to;
      exp_t       got, e;
      logic [3:0] order;
`ifdef ALU_ARB_FIXED_PRIO_EN
      order = 4'b0000;
`else
      order = 4'b1010;
`endif
      set_req(1'b0, 4'd5, 4'd9, 2'b11);
      set_req(1'b1, 4'd12, 4'd10, 2'b10);
      bus.i_rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_hs(rdy, n, to);
         checks++;
         if (to || rdy !== (order[k] ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL b2b_grant op %0d got %b want id %b", k, rdy, order[k]);
         end
         if (k > 0) begin
            checks++;
            if (n != 0) begin
               errors++; $display("FAIL b2b_throughput op %0d got gap %0d want 0", k, n);
            end
         end
         wait_rsp(got, n, to);
         pop_exp(e);
         checks++;
         if (to || got !== e) begin
            errors++; $display("FAIL b2b_rsp op %0d got %h want %h", k, got, e);
         end
         @(negedge clk);
      end
      bus.i_req_valid = 2'b00;
   endtask

   task automatic test_backpressure();
      logic [1:0] rdy;
      int         n;
      logic       to;
      exp_t       got, e;
      set_req(1'b0, 4'd6, 4'd3, 2'b10);
      bus.i_rsp_ready = 1'b0;
      wait_hs(rdy, n, to);
      bus.i_req_valid = 2'b00;
      set_req(1'b1, 4'd9, 4'd4, 2'b11);
      wait_rsp(got, n, to);
      pop_exp(e);
      checks++;
      if (to || got !== e) begin
         errors++; $display("FAIL bp_rsp got %h want %h", got, e);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         bus.i_req1_arg0 = 4'($urandom);
         bus.i_req1_arg1 = 4'($urandom);
         bus.i_req1_oper = 2'($urandom);
         #1;
         checks++;
         if (bus.o_rsp_valid !== 1'b1 || bus.o_req_ready !== 2'b00 ||
             {bus.o_rsp_id, bus.o_rsp_flag, bus.o_rsp_result} !== got) begin
            errors++; $display("FAIL bp_hold cycle %0d got v%b r%b %h want v1 r00 %h", c,
                               bus.o_rsp_valid, bus.o_req_ready,
                               {bus.o_rsp_id, bus.o_rsp_flag, bus.o_rsp_result}, got);
         end
      end
      @(negedge clk);
      bus.i_rsp_ready = 1'b1;
      wait_hs(rdy, n, to);
      bus.i_req_valid = 2'b00;
      checks++;
      if (to || rdy !== 2'b10 || n != 1) begin
         errors++; $display("FAIL bp_next_grant got %b gap %0d want 10 gap 1", rdy, n);
      end
      wait_rsp(got, n, to);
      pop_exp(e);
      checks++;
      if (to || got !== e) begin
         errors++; $display("FAIL bp_next_rsp got %h want %h", got, e);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_exec();
      logic [1:0] rdy;
      int         n;
      logic       to;
      exp_t       got, e;
      set_req(1'b0, 4'd2, 4'd2, 2'b11);
      bus.i_rsp_ready = 1'b1;
      wait_hs(rdy, n, to);
      rstn = 1'b0;
      bus.i_req_valid = 2'b00;
      @(negedge clk);
      rstn = 1'b1;
      exp_q.delete();
      b_ptr = 1'b0;
      #1;
      checks++;
      if (bus.o_busy !== 1'b0 || bus.o_rsp_valid !== 1'b0 || bus.o_op_cnt !== 8'd0) begin
         errors++; $display("FAIL rst_exec got busy %b valid %b cnt %0d want 0 0 0",
                            bus.o_busy, bus.o_rsp_valid, bus.o_op_cnt);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if (bus.o_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_exec_stale cycle %0d got %b want 0", c,
                               bus.o_rsp_valid);
         end
      end
      @(negedge clk);
      set_req(1'b0, 4'd1, 4'd2, 2'b00);
      set_req(1'b1, 4'd3, 4'd4, 2'b01);
      wait_hs(rdy, n, to);
      bus.i_req_valid = 2'b00;
      checks++;
      if (to || rdy !== 2'b01) begin
         errors++; $display("FAIL rst_exec_favour got %b want 01", rdy);
      end
      wait_rsp(got, n, to);
      pop_exp(e);
      checks++;
      if (to || got !== e) begin
         errors++; $display("FAIL rst_exec_rsp got %h want %h", got, e);
      end
      @(negedge clk);
   endtask

   task automatic test_cnt_wrap();
      logic [1:0] rdy;
      int         n;
      logic       to;
      exp_t       got, e;
      rstn = 1'b0;
      bus.i_req_valid = 2'b00;
      @(negedge clk);
      rstn = 1'b1;
      b_ptr = 1'b0;
      exp_q.delete();
      bus.i_rsp_ready = 1'b1;
      for (int k = 0; k < 256; k++) begin
         set_req(1'(k), 4'($urandom), 4'($urandom), 2'($urandom));
         wait_hs(rdy, n, to);
         bus.i_req_valid = 2'b00;
         wait_rsp(got, n, to);
         pop_exp(e);
         checks++;
         if (to || got !== e) begin
            errors++; $display("FAIL wrap_rsp op %0d got %h want %h", k, got, e);
         end
         @(negedge clk);
         #1;
         checks++;
         if (bus.o_op_cnt !== 8'(k + 1)) begin
            errors++; $display("FAIL wrap_cnt op %0d got %0d want %0d", k, bus.o_op_cnt,
                               8'(k + 1));
         end
      end
      checks++;
      if (bus.o_op_cnt !== 8'd0) begin
         errors++; $display("FAIL wrap_final got %0d want 0", bus.o_op_cnt);
      end
   endtask

   initial begin
      rstn            = 1'b0;
      bus.i_req_valid = 2'b00;
      bus.i_rsp_ready = 1'b0;
      bus.i_req0_arg0 = 4'd0;
      bus.i_req0_arg1 = 4'd0;
      bus.i_req0_oper = 2'b00;
      bus.i_req1_arg0 = 4'd0;
      bus.i_req1_arg1 = 4'd0;
      bus.i_req1_oper = 2'b00;
      @(negedge clk);
      test_reset();
      test_req0_single();
      test_req1_busy();
      test_back_to_back();
      test_backpressure();
      test_reset_exec();
      test_cnt_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
